// File: rtl/ball_motion_ctrl.sv
// Per-frame ball motion sequencer: Avalon-written velocity/control registers,
// one step-and-bounce sequence per frame at the start of vertical blanking.
module ball_motion_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int RADIUS   = 30,
  parameter int X_INIT   = 400,
  parameter int Y_INIT   = 300
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        write,
  input  logic [2:0]  address,
  input  logic [7:0]  writedata,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  output logic [10:0] ball_x,
  output logic [9:0]  ball_y,
  output logic        frame_tick,
  output logic        busy
);

  localparam logic [10:0]        X_MIN   = 11'(RADIUS);
  localparam logic [10:0]        X_MAX   = 11'(H_ACTIVE - 1 - RADIUS);
  localparam logic [9:0]         Y_MIN   = 10'(RADIUS);
  localparam logic [9:0]         Y_MAX   = 10'(V_ACTIVE - 1 - RADIUS);
  localparam logic signed [12:0] X_MIN_S = 13'(RADIUS);
  localparam logic signed [12:0] X_MAX_S = 13'(H_ACTIVE - 1 - RADIUS);
  localparam logic signed [12:0] Y_MIN_S = 13'(RADIUS);
  localparam logic signed [12:0] Y_MAX_S = 13'(V_ACTIVE - 1 - RADIUS);

  typedef enum logic [2:0] {IDLE, SAMPLE, STEP_X, STEP_Y, COMMIT} state_t;

  state_t             state_r;
  logic signed [7:0]  vx_r, vy_r, vx_w_r, vy_w_r;
  logic               en_r, load_r, mv_r;
  logic [10:0]        px_r, nx_r, nx_s;
  logic [9:0]         py_r, ny_r, ny_s;
  logic [7:0]         div_r, div_cnt_r;
  logic signed [12:0] tx_s, ty_s;
  logic               bounce_x_s, bounce_y_s, fs_s, we_s;

  // Negating -128 would overflow, so reflection saturates to +127.
  function automatic logic signed [7:0] neg_sat(input logic signed [7:0] v);
    if (v == 8'sh80) neg_sat = 8'sh7f;
    else             neg_sat = -v;
  endfunction

  function automatic logic [10:0] clamp_x(input logic [10:0] p);
    if (p < X_MIN)      clamp_x = X_MIN;
    else if (p > X_MAX) clamp_x = X_MAX;
    else                clamp_x = p;
  endfunction

  function automatic logic [9:0] clamp_y(input logic [9:0] p);
    if (p < Y_MIN)      clamp_y = Y_MIN;
    else if (p > Y_MAX) clamp_y = Y_MAX;
    else                clamp_y = p;
  endfunction

  assign fs_s = (vcount == 10'(V_ACTIVE)) && (hcount == 11'd0);
  assign we_s = chipselect && write;

  // Candidate X centre: pending-position load, velocity step with bounce, or hold.
  always_comb begin
    tx_s       = $signed({2'b00, ball_x}) + $signed({{5{vx_w_r[7]}}, vx_w_r});
    nx_s       = ball_x;
    bounce_x_s = 1'b0;
    if (load_r) begin
      nx_s = clamp_x(px_r);
    end else if (mv_r) begin
      if (tx_s > X_MAX_S) begin
        nx_s       = X_MAX;
        bounce_x_s = 1'b1;
      end else if (tx_s < X_MIN_S) begin
        nx_s       = X_MIN;
        bounce_x_s = 1'b1;
      end else begin
        nx_s       = tx_s[10:0];
      end
    end else begin
      nx_s = ball_x;
    end
  end

  // Candidate Y centre, same rules as X.
  always_comb begin
    ty_s       = $signed({3'b000, ball_y}) + $signed({{5{vy_w_r[7]}}, vy_w_r});
    ny_s       = ball_y;
    bounce_y_s = 1'b0;
    if (load_r) begin
      ny_s = clamp_y(py_r);
    end else if (mv_r) begin
      if (ty_s > Y_MAX_S) begin
        ny_s       = Y_MAX;
        bounce_y_s = 1'b1;
      end else if (ty_s < Y_MIN_S) begin
        ny_s       = Y_MIN;
        bounce_y_s = 1'b1;
      end else begin
        ny_s       = ty_s[9:0];
      end
    end else begin
      ny_s = ball_y;
    end
  end

  // Sequencer plus register file; the Avalon write comes last so it beats FSM write-backs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      ball_x     <= 11'(X_INIT);
      ball_y     <= 10'(Y_INIT);
      px_r       <= 11'(X_INIT);
      py_r       <= 10'(Y_INIT);
      nx_r       <= 11'(X_INIT);
      ny_r       <= 10'(Y_INIT);
      vx_r       <= 8'sd0;
      vy_r       <= 8'sd0;
      vx_w_r     <= 8'sd0;
      vy_w_r     <= 8'sd0;
      en_r       <= 1'b0;
      load_r     <= 1'b0;
      mv_r       <= 1'b0;
      div_r      <= 8'd0;
      div_cnt_r  <= 8'd0;
      frame_tick <= 1'b0;
      busy       <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      case (state_r)
        IDLE: begin
          if (fs_s) begin
            state_r <= SAMPLE;
            busy    <= 1'b1;
          end else begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end
        end
        SAMPLE: begin
          vx_w_r    <= vx_r;
          vy_w_r    <= vy_r;
          mv_r      <= en_r && (div_cnt_r == 8'd0);
          div_cnt_r <= (div_cnt_r == 8'd0) ? div_r : (div_cnt_r - 8'd1);
          state_r   <= STEP_X;
        end
        STEP_X: begin
          nx_r <= nx_s;
          if (bounce_x_s) vx_r <= neg_sat(vx_w_r);
          state_r <= STEP_Y;
        end
        STEP_Y: begin
          ny_r <= ny_s;
          if (bounce_y_s) vy_r <= neg_sat(vy_w_r);
          state_r    <= COMMIT;
          frame_tick <= 1'b1;
        end
        COMMIT: begin
          ball_x  <= nx_r;
          ball_y  <= ny_r;
          load_r  <= 1'b0;
          state_r <= IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase

      if (we_s) begin
        case (address)
          3'd0: vx_r <= writedata;
          3'd1: vy_r <= writedata;
          3'd2: begin
            en_r   <= writedata[0];
            load_r <= writedata[1];
          end
          3'd3: px_r[7:0]  <= writedata;
          3'd4: px_r[10:8] <= writedata[2:0];
          3'd5: py_r[7:0]  <= writedata;
          3'd6: py_r[9:8]  <= writedata[1:0];
          3'd7: div_r      <= writedata;
          default: div_r   <= div_r;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Self-checking bench for ball_motion_ctrl: directed scenarios plus randomized
// register traffic, compared every cycle against a behavioural frame model.
module tb_ball_motion_ctrl;

  localparam int FRAME_LEN = 32;
  localparam int XMIN = 30, XMAX = 609, YMIN = 30, YMAX = 449;

  logic        clk, reset, chipselect, write;
  logic [2:0]  address;
  logic [7:0]  writedata;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic [10:0] ball_x;
  logic [9:0]  ball_y;
  logic        frame_tick, busy;

  ball_motion_ctrl dut (
    .clk(clk), .reset(reset), .chipselect(chipselect), .write(write),
    .address(address), .writedata(writedata), .hcount(hcount), .vcount(vcount),
    .ball_x(ball_x), .ball_y(ball_y), .frame_tick(frame_tick), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec, n_miss, fpos, bz_cnt, ft_cnt;
  // model: software-visible registers, committed ball, and cycles elapsed since fs
  int m_vx, m_vy, m_en, m_load, m_px, m_py, m_div, m_dc, m_bx, m_by;
  int m_ph, w_vx, w_vy, m_mv, m_nx, m_ny;
  int xs[6];

  function automatic int s8(input int d);
    return (d >= 128) ? d - 256 : d;
  endfunction

  function automatic int neg_sat(input int v);
    return (v == -128) ? 127 : -v;
  endfunction

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  task automatic model_reset();
    m_vx = 0; m_vy = 0; m_en = 0; m_load = 0; m_px = 400; m_py = 300;
    m_div = 0; m_dc = 0; m_bx = 400; m_by = 300; m_ph = 0;
    w_vx = 0; w_vy = 0; m_mv = 0; m_nx = 400; m_ny = 300;
  endtask

  // One axis of a frame step: returns new position, reports whether it bounced.
  task automatic axis(input int pos, input int p, input int v, input int lo, input int hi,
                      output int np, output int bounced);
    int t;
    bounced = 0;
    if (m_load != 0) np = clampi(p, lo, hi);
    else if (m_mv != 0) begin
      t = pos + v;
      if (t > hi) begin np = hi; bounced = 1; end
      else if (t < lo) begin np = lo; bounced = 1; end
      else np = t;
    end else np = pos;
  endtask

  task automatic model_step(input bit fs, input bit we, input int a, input int d);
    int b;
    if (m_ph == 0) begin
      if (fs) m_ph = 1;
    end else if (m_ph == 1) begin
      w_vx = m_vx; w_vy = m_vy;
      m_mv = (m_en != 0 && m_dc == 0) ? 1 : 0;
      m_dc = (m_dc == 0) ? m_div : m_dc - 1;
      m_ph = 2;
    end else if (m_ph == 2) begin
      axis(m_bx, m_px, w_vx, XMIN, XMAX, m_nx, b);
      if (b != 0) m_vx = neg_sat(w_vx);
      m_ph = 3;
    end else if (m_ph == 3) begin
      axis(m_by, m_py, w_vy, YMIN, YMAX, m_ny, b);
      if (b != 0) m_vy = neg_sat(w_vy);
      m_ph = 4;
    end else begin
      m_bx = m_nx; m_by = m_ny; m_load = 0; m_ph = 0;
    end
    if (we) begin
      case (a)
        0: m_vx = s8(d);
        1: m_vy = s8(d);
        2: begin m_en = d & 1; m_load = (d >> 1) & 1; end
        3: m_px = (m_px & 'h700) | d;
        4: m_px = (m_px & 'hFF) | ((d & 7) << 8);
        5: m_py = (m_py & 'h300) | d;
        6: m_py = (m_py & 'hFF) | ((d & 3) << 8);
        default: m_div = d;
      endcase
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, advance the model, then compare all outputs.
  task automatic tick(input logic cs, input logic wr, input logic [2:0] a, input logic [7:0] d);
    logic fs_b;
    chipselect = cs; write = wr; address = a; writedata = d;
    hcount = 11'(fpos);
    vcount = (fpos < FRAME_LEN / 2) ? 10'd480 : 10'd100;
    fs_b = (vcount == 10'd480) && (hcount == 11'd0);
    @(posedge clk);
    if (reset) model_reset();
    else model_step(fs_b, cs && wr, int'(a), int'(d));
    @(negedge clk);
    fpos = (fpos + 1) % FRAME_LEN;
    chk("ball_x", int'(ball_x), m_bx);
    chk("ball_y", int'(ball_y), m_by);
    chk("busy", int'(busy), (m_ph != 0) ? 1 : 0);
    chk("frame_tick", int'(frame_tick), (m_ph == 4) ? 1 : 0);
    if (busy) bz_cnt++;
    if (frame_tick) ft_cnt++;
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, 3'd0, 8'd0);
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    tick(1'b1, 1'b1, a, d);
  endtask

  task automatic to_fs();
    while (fpos != 0) idle();
  endtask

  task automatic frame();
    to_fs();
    idle();
    repeat (4) idle();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    reset = 1'b0;
  endtask

  initial begin
    n_vec = 0; n_miss = 0; fpos = 3; bz_cnt = 0; ft_cnt = 0;
    reset = 1'b1; chipselect = 1'b0; write = 1'b0; address = 3'd0; writedata = 8'd0;
    hcount = 11'd0; vcount = 10'd0;
    model_reset();
    @(negedge clk);
    do_reset();
    chk("reset_x", int'(ball_x), 400);
    chk("reset_y", int'(ball_y), 300);

    // EN=0 frame: no motion, busy for 4 cycles, one frame_tick
    bz_cnt = 0; ft_cnt = 0;
    frame();
    chk("idle_frame_x", int'(ball_x), 400);
    chk("idle_frame_y", int'(ball_y), 300);
    chk("busy_cycles", bz_cnt, 4);
    chk("tick_count", ft_cnt, 1);

    // one step with VX=2, VY=-3; position commits on the 4th clock after fs
    wr(3'd0, 8'd2); wr(3'd1, 8'hFD); wr(3'd7, 8'd0); wr(3'd2, 8'd1);
    to_fs();
    idle();
    repeat (3) idle();
    chk("pre_commit_x", int'(ball_x), 400);
    idle();
    chk("step_x", int'(ball_x), 402);
    chk("step_y", int'(ball_y), 297);

    // load 607, then bounce off the right edge and travel back
    wr(3'd2, 8'd0); wr(3'd3, 8'h5F); wr(3'd4, 8'h02); wr(3'd2, 8'd2);
    frame();
    chk("load_x", int'(ball_x), 607);
    wr(3'd0, 8'd5); wr(3'd2, 8'd1);
    frame();
    chk("bounce_x", int'(ball_x), 609);
    chk("model_vx", m_vx, -5);
    frame();
    chk("return_x", int'(ball_x), 604);

    // divider: step every third frame
    do_reset();
    wr(3'd7, 8'd2); wr(3'd0, 8'd1); wr(3'd2, 8'd1);
    for (int i = 0; i < 6; i++) begin
      frame();
      xs[i] = int'(ball_x);
    end
    chk("div_f1", xs[0], 401);
    chk("div_f3", xs[2], 401);
    chk("div_f4", xs[3], 402);
    chk("div_f6", xs[5], 402);

    // out-of-range load is clamped and only takes effect at the frame
    do_reset();
    frame();
    wr(3'd4, 8'h07); wr(3'd3, 8'hFF); wr(3'd2, 8'd2);
    repeat (4) idle();
    chk("load_wait_x", int'(ball_x), 400);
    frame();
    chk("load_clamp_x", int'(ball_x), 609);
    chk("model_load_clr", m_load, 0);

    // asynchronous reset in STEP_Y discards the staged move
    do_reset();
    wr(3'd0, 8'd2); wr(3'd2, 8'd1);
    frame();
    chk("pre_rst_x", int'(ball_x), 402);
    to_fs();
    repeat (3) idle();
    reset = 1'b1;
    #1;
    chk("async_rst_x", int'(ball_x), 400);
    chk("async_rst_busy", int'(busy), 0);
    ft_cnt = 0;
    idle();
    reset = 1'b0;
    repeat (6) idle();
    chk("rst_no_tick", ft_cnt, 0);
    chk("rst_y", int'(ball_y), 300);

    // randomized register traffic across many frames
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      logic [2:0] a;
      logic [7:0] d;
      a = 3'($urandom_range(0, 7));
      d = (a == 3'd7) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
      if ($urandom_range(0, 799) == 0) begin
        do_reset();
      end else if ($urandom_range(0, 3) == 0) begin
        tick(($urandom_range(0, 4) != 0), 1'b1, a, d);
      end else begin
        idle();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
